// File: rtl/race_arb_pkg.sv
// Shared types and default sizing for the race arbiter bank.
package race_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RACE = 2'd1,
    ST_DONE = 2'd2
  } race_state_t;

  localparam int N_CH_DEF    = 8;
  localparam int TIMEOUT_DEF = 200;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/race_arb_channel.sv
// One race judge: input capture, edge history, lock and result flops.
// RACE_ARB_SYNC_EN selects a two-flop synchroniser instead of a single capture flop.
module race_arb_channel #(
  parameter logic TIE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic racing,
  input  logic force_to,
  input  logic fin1,
  input  logic fin2,
  output logic out,
  output logic tie,
  output logic timeout,
  output logic settled
);

  logic samp1, samp2;
  logic hist1, hist2;
  logic lock;
  logic r1, r2, hit;

`ifdef RACE_ARB_SYNC_EN
  logic [1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sync1[0], fin1};
      sync2 <= {sync2[0], fin2};
    end
  end

  assign samp1 = sync1[1];
  assign samp2 = sync2[1];
`else
  logic cap1, cap2;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap1 <= 1'b0;
      cap2 <= 1'b0;
    end else begin
      cap1 <= fin1;
      cap2 <= fin2;
    end
  end

  assign samp1 = cap1;
  assign samp2 = cap2;
`endif

  assign r1  = samp1 & ~hist1;
  assign r2  = samp2 & ~hist2;
  assign hit = racing & ~lock & (r1 | r2);

  // Look-ahead so the top can finish the race on the edge that registers the last result.
  assign settled = lock | hit;

  // History tracks the sample every cycle, so the arm edge loads the current level.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist1   <= 1'b0;
      hist2   <= 1'b0;
      lock    <= 1'b0;
      out     <= 1'b0;
      tie     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      hist1 <= samp1;
      hist2 <= samp2;
      if (arm) begin
        lock    <= 1'b0;
        out     <= 1'b0;
        tie     <= 1'b0;
        timeout <= 1'b0;
      end else if (hit) begin
        lock <= 1'b1;
        if (r1 && r2) begin
          tie <= 1'b1;
          out <= TIE_VAL;
        end else begin
          out <= r1;
        end
      end else if (racing && !lock && force_to) begin
        lock    <= 1'b1;
        timeout <= 1'b1;
        out     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/race_arbiter_bank.sv
// Parallel arbiter-PUF race judge bank with a shared timeout counter.
// Build option RACE_ARB_SYNC_EN: two-flop synchroniser on every finished line.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// RACE  | channels armed, counter running
// DONE  | results valid and held until the next start
module race_arbiter_bank
  import race_arb_pkg::*;
#(
  parameter int   N_CH    = N_CH_DEF,
  parameter int   TIMEOUT = TIMEOUT_DEF,
  parameter int   CNT_W   = CNT_W_DEF,
  parameter logic TIE_VAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            global_rst,
  input  logic            start,
  input  logic [N_CH-1:0] finished1,
  input  logic [N_CH-1:0] finished2,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] tie,
  output logic [N_CH-1:0] timeout,
  output logic            busy,
  output logic            done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  race_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0]  settled;
  logic             rst_any;
  logic             racing;
  logic             arm;
  logic             to_hit;
  logic             all_res;

  assign rst_any = rst | global_rst;
  assign racing  = (state == ST_RACE);
  assign arm     = start & ~racing;
  assign to_hit  = racing & (cnt == CNT_LAST);
  assign all_res = &settled;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    race_arb_channel #(
      .TIE_VAL (TIE_VAL)
    ) u_ch (
      .clk      (clk),
      .rst      (rst_any),
      .arm      (arm),
      .racing   (racing),
      .force_to (to_hit),
      .fin1     (finished1[i]),
      .fin2     (finished2[i]),
      .out      (out[i]),
      .tie      (tie[i]),
      .timeout  (timeout[i]),
      .settled  (settled[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RACE;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        ST_RACE: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          if (all_res || to_hit) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
